// File: rtl/prod_requant_pkg.sv
// prod_requant_pkg: shared constants and packed-field helpers for the
// product requantiser.
//   - DEF_SHIFT is tied to the fractional bits of the twiddle ROM coefficients.
//   - The re_hi/re_lo/im_hi helpers and IM_LO locate the two halves of a packed
//     complex word {re, im}, where w is the width of one component.
package prod_requant_pkg;

  // Twiddle ROM coefficients are Q1.7, so the product carries 7 extra fraction bits.
  localparam int unsigned TW_FRAC_BITS = 7;

  localparam int unsigned DEF_NBITS = 8;
  localparam int unsigned DEF_SHIFT = TW_FRAC_BITS;
  localparam int unsigned DEF_CNTW  = 16;

  localparam int unsigned IM_LO = 0;

  function automatic int unsigned re_hi(input int unsigned w);
    return 2 * w - 1;
  endfunction

  function automatic int unsigned re_lo(input int unsigned w);
    return w;
  endfunction

  function automatic int unsigned im_hi(input int unsigned w);
    return w - 1;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// requant_lane: combinational requantisation for one signed component.
// The logic has two independent halves so the parent can register between them.
//   x   : full-precision product component, signed 2*NBITS bits
//   rnd : x rounded half-up and arithmetically shifted right by SHIFT
//         (2*NBITS+1-SHIFT bits)
//   rin : registered copy of rnd, fed back from the parent's first stage
//   y   : rin clamped to the signed NBITS range
//   sat : high when the clamp changed the value
module requant_lane
  import prod_requant_pkg::*;
#(
  parameter int unsigned NBITS = DEF_NBITS,
  parameter int unsigned SHIFT = DEF_SHIFT
) (
  input  logic [2*NBITS-1:0]     x,
  output logic [2*NBITS-SHIFT:0] rnd,
  input  logic [2*NBITS-SHIFT:0] rin,
  output logic [NBITS-1:0]       y,
  output logic                   sat
);

  localparam int unsigned XW = 2 * NBITS + 1;
  localparam int unsigned RW = XW - SHIFT;

  // Half an output LSB. This is zero when SHIFT is 0, which means no rounding is applied.
  localparam logic [XW-1:0] HALF = XW'((64'd1 << SHIFT) >> 1);

  logic [XW-1:0] sum;

  // The extra sign bit gives headroom, so adding HALF cannot overflow.
  assign sum = {x[2*NBITS-1], x} + HALF;

  // Dropping the low SHIFT bits of a sign-extended value is an arithmetic shift.
  assign rnd = sum[XW-1:SHIFT];

  // The value fits in NBITS only if every bit from NBITS-1 upward copies the sign.
  logic [RW-NBITS:0] upper;
  assign upper = rin[RW-1:NBITS-1];

  always_comb begin
    sat = !((&upper) || !(|upper));
    y   = rin[NBITS-1:0];
    if (sat) begin
      y = rin[RW-1] ? {1'b1, {(NBITS-1){1'b0}}} : {1'b0, {(NBITS-1){1'b1}}};
    end
  end

endmodule

// File: rtl/prod_requant.sv
// prod_requant: converts full-precision complex twiddle products back to sample
// width for the next butterfly stage. The design is a 2-stage elastic pipeline:
// stage 1 rounds and shifts, and stage 2 clamps.
//   clk, rst        : clock, synchronous active-high reset
//   in_data         : {re, im}, each a signed 2*NBITS product
//   in_valid/ready  : input handshake. in_ready depends only on out_ready and state.
//   out_data        : {re, im}, each a signed NBITS sample
//   out_valid/ready : output handshake
//   out_sat         : at least one component of out_data was clamped
//   sat_cnt         : number of output transfers with out_sat set. It stops at all-ones.
//   sat_clr         : clears sat_cnt and takes priority over a same-cycle increment
module prod_requant
  import prod_requant_pkg::*;
#(
  parameter int unsigned NBITS = DEF_NBITS,
  parameter int unsigned SHIFT = DEF_SHIFT,
  parameter int unsigned CNTW  = DEF_CNTW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*NBITS-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*NBITS-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sat,
  output logic [CNTW-1:0]      sat_cnt,
  input  logic                 sat_clr
);

  localparam int unsigned IW = 2 * NBITS;
  localparam int unsigned RW = 2 * NBITS + 1 - SHIFT;

  localparam int unsigned IN_RE_HI  = re_hi(IW);
  localparam int unsigned IN_RE_LO  = re_lo(IW);
  localparam int unsigned IN_IM_HI  = im_hi(IW);
  localparam int unsigned OUT_RE_HI = re_hi(NBITS);
  localparam int unsigned OUT_RE_LO = re_lo(NBITS);
  localparam int unsigned OUT_IM_HI = im_hi(NBITS);

  logic [RW-1:0]    re_rnd, im_rnd;
  logic [RW-1:0]    s1_re_q, s1_im_q;
  logic             s1_valid_q;
  logic [NBITS-1:0] re_y, im_y;
  logic             re_sat, im_sat;

  logic [2*NBITS-1:0] out_data_q;
  logic               out_valid_q;
  logic               out_sat_q;
  logic [CNTW-1:0]    sat_cnt_q, sat_cnt_d;

  logic s1_load, s2_load, out_xfer;

  requant_lane #(
    .NBITS (NBITS),
    .SHIFT (SHIFT)
  ) u_lane_re (
    .x   (in_data[IN_RE_HI:IN_RE_LO]),
    .rnd (re_rnd),
    .rin (s1_re_q),
    .y   (re_y),
    .sat (re_sat)
  );

  requant_lane #(
    .NBITS (NBITS),
    .SHIFT (SHIFT)
  ) u_lane_im (
    .x   (in_data[IN_IM_HI:IM_LO]),
    .rnd (im_rnd),
    .rin (s1_im_q),
    .y   (im_y),
    .sat (im_sat)
  );

  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // Masked so that a sample stored before reset never appears as a transfer in the reset cycle.
  assign out_valid = out_valid_q && !rst;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_cnt   = sat_cnt_q;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (out_xfer && out_sat_q && !(&sat_cnt_q)) begin
      sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_re_q     <= '0;
      s1_im_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_re_q <= re_rnd;
          s1_im_q <= im_rnd;
        end
      end
      if (s2_load) begin
        out_valid_q <= s1_valid_q;
        // Payload changes only when a real sample arrives, so out_sat always describes out_data.
        if (s1_valid_q) begin
          out_data_q[OUT_RE_HI:OUT_RE_LO] <= re_y;
          out_data_q[OUT_IM_HI:IM_LO]     <= im_y;
          out_sat_q                       <= re_sat || im_sat;
        end
      end
      sat_cnt_q <= sat_cnt_d;
    end
  end

endmodule

// File: tb/tb_prod_requant.sv
// tb_prod_requant: directed and randomised bench for prod_requant (NBITS=8, SHIFT=7, CNTW=16).
// Inputs are driven 1 time unit after the rising edge. Outputs and handshakes are sampled on the
// falling edge.
module tb_prod_requant;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sat;
  logic [15:0] sat_cnt;
  logic        sat_clr;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  prod_requant dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sat   (out_sat),
    .sat_cnt   (sat_cnt),
    .sat_clr   (sat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference for one component: round half up, shift right by 7, clamp to 8 bits. Returns {sat, y}.
  function automatic logic [8:0] ref_comp(input logic [15:0] x);
    int v;
    v = int'($signed(x)) + 64;
    v = v >>> 7;
    if (v > 127) return {1'b1, 8'h7f};
    if (v < -128) return {1'b1, 8'h80};
    return {1'b0, 8'(v)};
  endfunction

  function automatic logic [16:0] ref_pair(input logic [31:0] d);
    logic [8:0] a, b;
    a = ref_comp(d[31:16]);
    b = ref_comp(d[15:0]);
    return {a[8] | b[8], a[7:0], b[7:0]};
  endfunction

  // Send one sample with an idle pipeline. Checks the 2-cycle latency, the result, and sat_cnt.
  task automatic xfer_one(input string tag, input int re, input int im, input int ere,
                          input int eim, input bit esat, input bit clr);
    in_data   = {16'(re), 16'(im)};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_lat"}, 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    check_eq({tag, "_vld"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_dat"}, 32'({out_sat, out_data}), 32'({esat, 8'(ere), 8'(eim)}));
    sat_clr = clr;
    tick();
    sat_clr = 1'b0;
    if (clr) exp_cnt = 0;
    else if (esat) exp_cnt++;
    check_eq({tag, "_cnt"}, 32'(sat_cnt), 32'(exp_cnt));
  endtask

  int d_re [10] = '{200, -192, 64, 63, -64, 16319, 16320, 0, 16320, 0};
  int d_im [10] = '{-200, 0, 0, 0, 192, -16448, 0, -32768, 0, -16449};
  int e_re [10] = '{2, -1, 1, 0, 0, 127, 127, 0, 127, 0};
  int e_im [10] = '{-2, 0, 0, 0, 2, -128, 0, -128, 0, -128};
  bit e_sat[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
  bit d_clr[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

  logic [16:0] exp_q[$];

  initial begin
    int sent, rcv, n_in, n_out, v;
    logic [16:0] e;

    // Reset held for 3 cycles while in_valid is high.
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_vld", 32'(out_valid), 32'd0);
      tick();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_rdy", 32'(in_ready), 32'd1);
    check_eq("rst_cnt", 32'(sat_cnt), 32'd0);
    check_eq("rst_dat", 32'({out_sat, out_data}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check_eq("rst_nostale", 32'(out_valid), 32'd0);
    end
    tick();

    // Directed rounding and saturation vectors.
    for (int i = 0; i < 10; i++) begin
      xfer_one($sformatf("dir%0d", i), d_re[i], d_im[i], e_re[i], e_im[i], e_sat[i], d_clr[i]);
      if (i == 7) check_eq("sat_cnt_two", 32'(sat_cnt), 32'd2);
      if (i == 8) check_eq("sat_clr_prio", 32'(sat_cnt), 32'd0);
    end

    // Backpressure: out_ready is low for cycles 3 to 7 while 1..10 (scaled by 128) streams in.
    sent = 0;
    rcv  = 0;
    for (int c = 0; c < 40 && rcv < 10; c++) begin
      v         = (sent + 1) * 128;
      in_valid  = (sent < 10);
      in_data   = {16'(v), 16'(-v)};
      out_ready = !(c >= 3 && c <= 7);
      @(negedge clk);
      if (c >= 3 && c <= 7) begin
        check_eq("bp_inrdy", 32'(in_ready), 32'd0);
        check_eq("bp_hold", 32'({out_valid, out_data}), 32'({1'b1, 8'(rcv + 1), 8'(-(rcv + 1))}));
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        check_eq("bp_out", 32'(out_data), 32'({8'(rcv + 1), 8'(-(rcv + 1))}));
        rcv++;
      end
      tick();
    end
    in_valid = 1'b0;
    check_eq("bp_count", 32'(rcv), 32'd10);
    check_eq("bp_satcnt", 32'(sat_cnt), 32'(exp_cnt));

    // Random valid/ready toggling with 1000 samples checked against the reference model.
    n_in  = 0;
    n_out = 0;
    for (int c = 0; c < 20000 && n_out < 1000; c++) begin
      in_valid  = (n_in < 1000) && ($urandom_range(3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(2) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_pair(in_data));
        n_in++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("rnd_extra", 32'd1, 32'(exp_q.size()));
        end else begin
          e = exp_q.pop_front();
          check_eq("rnd_out", 32'({out_sat, out_data}), 32'(e));
          if (e[16] && exp_cnt != 65535) exp_cnt++;
        end
        n_out++;
      end
      tick();
    end
    in_valid = 1'b0;
    check_eq("rnd_in_count", 32'(n_in), 32'd1000);
    check_eq("rnd_inout", 32'(n_out), 32'(n_in));
    check_eq("rnd_satcnt", 32'(sat_cnt), 32'(exp_cnt));
    @(negedge clk);
    check_eq("rnd_empty", 32'(out_valid), 32'd0);
    tick();

    // Reset in the middle of a stream while both stages are full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {16'(640), 16'(640)};
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    check_eq("mid_full_vld", 32'(out_valid), 32'd1);
    check_eq("mid_full_rdy", 32'(in_ready), 32'd0);
    tick();
    rst       = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_noxfer", 32'(out_valid), 32'd0);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_after_vld", 32'(out_valid), 32'd0);
    check_eq("mid_after_rdy", 32'(in_ready), 32'd1);
    check_eq("mid_after_cnt", 32'(sat_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check_eq("mid_nostale", 32'(out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
